// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator with sub-word extension and read-modify-write stores
module mem_access_unit #(
  parameter int MEM_WORDS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);
  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, DONE} state_t;
  state_t state, nxt;
  logic [31:0] addr_q, wdata_q, merge_q, mask, merged, ld_val;
  logic [1:0]  size_q;
  logic        sgn_q, fault_q, req_fault;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [4:0]  sh;
  assign req_fault = (req_size == 2'b11) | (req_size == 2'b01 & req_addr[0]) |
                     (req_size == 2'b10 & |req_addr[1:0]) | (req_addr[31:2] >= 30'(MEM_WORDS));
  assign sh     = {addr_q[1:0], 3'b000};
  assign lane_b = 8'(mem_rd >> sh);
  assign lane_h = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
  assign ld_val = size_q == 2'b00 ? {{24{sgn_q & lane_b[7]}}, lane_b} :
                  size_q == 2'b01 ? {{16{sgn_q & lane_h[15]}}, lane_h} : mem_rd;
  // Sub-word stores only ever see byte or halfword sizes here; faults never reach RMW.
  assign mask   = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
  assign merged = (mem_rd & ~mask) | ((wdata_q << sh) & mask);
  always_comb begin
    nxt      = state;
    stall    = 1'b0;
    done     = 1'b0;
    fault    = 1'b0;
    mem_we   = 1'b0;
    mem_addr = {2'b00, addr_q[31:2]};
    mem_wd   = state == RMW_WR ? merge_q : wdata_q;
    unique case (state)
      IDLE:    nxt = !req_valid ? IDLE : req_fault ? DONE : !req_we ? LOAD :
                     req_size == 2'b10 ? STORE : RMW_RD;
      LOAD:    nxt = DONE;
      STORE:   nxt = DONE;
      RMW_RD:  nxt = RMW_WR;
      RMW_WR:  nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    stall  = ~rst & ((state == IDLE & req_valid) | (state inside {LOAD, STORE, RMW_RD, RMW_WR}));
    done   = state == DONE;
    fault  = done & fault_q;
    mem_we = ~rst & (state == STORE | state == RMW_WR);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      fault_q <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        sgn_q   <= req_signed;
        fault_q <= req_fault;
      end
      if (state == LOAD) rdata <= ld_val;
      if (state == RMW_RD) merge_q <= merged;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven and random-stream checks of mem_access_unit against a word memory model
module tb_mem_access_unit;
  logic        clk = 1'b0, rst = 1'b1, mem_init = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        stall, done, fault, mem_we;
  logic [31:0] rdata, mem_addr, mem_wd, mem_rd;
  logic [31:0] mem [100];
  logic [31:0] ref_mem [100];
  logic [31:0] ref_rdata;
  int          cyc = 0, ncmp = 0, nbad = 0, stall_cnt = 0, we_cnt = 0;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    logic [31:0] word;
    bit          chk;
    int          idx;
    int          lat;
    int          wes;
    int          start;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        fault;
    logic [31:0] rdata;
    logic [31:0] word;
    int          lat;
  } vec_t;

  exp_t q[$];
  vec_t vt[$];

  mem_access_unit #(.MEM_WORDS(100)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
    .done(done), .fault(fault), .rdata(rdata), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rd = (mem_addr < 32'd100) ? mem[mem_addr[6:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 100; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    else if (mem_we && mem_addr < 32'd100) mem[mem_addr[6:0]] <= mem_wd;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: lane-indexed part-selects over the bench's own memory image.
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd, output exp_t e);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    e.chk   = addr[31:2] < 30'd100;
    e.idx   = e.chk ? int'(addr[8:2]) : 0;
    e.fault = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00) || !e.chk;
    e.lat   = e.fault ? 2 : (we && size != 2'b10) ? 4 : 3;
    e.wes   = (!e.fault && we) ? 1 : 0;
    e.start = 0;
    if (!e.fault) begin
      w = ref_mem[e.idx];
      if (we) begin
        if (size == 2'b00) w[addr[1:0]*8 +: 8] = wd[7:0];
        else if (size == 2'b01) w[addr[1]*16 +: 16] = wd[15:0];
        else w = wd;
        ref_mem[e.idx] = w;
      end else begin
        b = w[addr[1:0]*8 +: 8];
        h = w[addr[1]*16 +: 16];
        if (size == 2'b00) ref_rdata = sgn ? {{24{b[7]}}, b} : {24'h0, b};
        else if (size == 2'b01) ref_rdata = sgn ? {{16{h[15]}}, h} : {16'h0, h};
        else ref_rdata = w;
      end
    end
    e.rdata = ref_rdata;
    e.word  = e.chk ? ref_mem[e.idx] : 32'h0;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd, input exp_t e);
    bit got = 0;
    e.start = cyc;
    q.push_back(e);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    if (!got) begin
      ncmp++; nbad++;
      $display("FAIL timeout: no done for addr %h, want done within 12 cycles", addr);
      void'(q.pop_back());
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_cnt = 0;
      we_cnt = 0;
    end else begin
      if (mem_we) we_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          ncmp++; nbad++;
          $display("FAIL spurious_done: done=1 with no request outstanding, want 0");
        end else begin
          e = q.pop_front();
          check("fault", 32'(fault), 32'(e.fault));
          check("rdata", rdata, e.rdata);
          check("latency", 32'(cyc - e.start + 1), 32'(e.lat));
          check("stall_cycles", 32'(stall_cnt), 32'(e.lat - 1));
          check("mem_we_pulses", 32'(we_cnt), 32'(e.wes));
          if (e.chk) check("mem_word", mem[e.idx], e.word);
        end
        stall_cnt = 0;
        we_cnt = 0;
      end else if (stall) stall_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e, m;
    logic [31:0] a;
    //           we  size   sgn  addr        wdata         flt  rdata         word          lat
    vt.push_back('{1'b1, 2'd2, 1'b0, 32'h008, 32'hDEADBEEF, 1'b0, 32'h00000000, 32'hDEADBEEF, 3});
    vt.push_back('{1'b0, 2'd2, 1'b0, 32'h008, 32'h0,        1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 3});
    vt.push_back('{1'b0, 2'd0, 1'b1, 32'h009, 32'h0,        1'b0, 32'hFFFFFFBE, 32'hDEADBEEF, 3});
    vt.push_back('{1'b0, 2'd0, 1'b0, 32'h009, 32'h0,        1'b0, 32'h000000BE, 32'hDEADBEEF, 3});
    vt.push_back('{1'b0, 2'd1, 1'b1, 32'h00A, 32'h0,        1'b0, 32'hFFFFDEAD, 32'hDEADBEEF, 3});
    vt.push_back('{1'b0, 2'd1, 1'b0, 32'h00A, 32'h0,        1'b0, 32'h0000DEAD, 32'hDEADBEEF, 3});
    vt.push_back('{1'b1, 2'd0, 1'b0, 32'h00B, 32'h00000012, 1'b0, 32'h0000DEAD, 32'h12ADBEEF, 4});
    vt.push_back('{1'b1, 2'd1, 1'b0, 32'h008, 32'hFFFFCAFE, 1'b0, 32'h0000DEAD, 32'h12ADCAFE, 4});
    vt.push_back('{1'b0, 2'd0, 1'b1, 32'h008, 32'h0,        1'b0, 32'hFFFFFFFE, 32'h12ADCAFE, 3});
    vt.push_back('{1'b0, 2'd1, 1'b0, 32'h005, 32'h0,        1'b1, 32'hFFFFFFFE, 32'h10000001, 2});
    vt.push_back('{1'b1, 2'd2, 1'b0, 32'h190, 32'h00000055, 1'b1, 32'hFFFFFFFE, 32'h0,        2});
    vt.push_back('{1'b0, 2'd3, 1'b0, 32'h000, 32'h0,        1'b1, 32'hFFFFFFFE, 32'h10000000, 2});
    vt.push_back('{1'b1, 2'd2, 1'b0, 32'h006, 32'h0BADF00D, 1'b1, 32'hFFFFFFFE, 32'h10000001, 2});
    vt.push_back('{1'b0, 2'd2, 1'b0, 32'h18C, 32'h0,        1'b0, 32'h10000063, 32'h10000063, 3});
    vt.push_back('{1'b1, 2'd0, 1'b0, 32'h18F, 32'hFFFFFF77, 1'b0, 32'h10000063, 32'h77000063, 4});
    vt.push_back('{1'b0, 2'd1, 1'b1, 32'h18E, 32'h0,        1'b0, 32'h00007700, 32'h77000063, 3});
    vt.push_back('{1'b0, 2'd0, 1'b0, 32'h18F, 32'h0,        1'b0, 32'h00000077, 32'h77000063, 3});
    vt.push_back('{1'b1, 2'd1, 1'b0, 32'h002, 32'h00008001, 1'b0, 32'h00000077, 32'h80010000, 4});
    vt.push_back('{1'b0, 2'd1, 1'b1, 32'h002, 32'h0,        1'b0, 32'hFFFF8001, 32'h80010000, 3});

    for (int i = 0; i < 100; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
    ref_rdata = 32'h0;
    req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; mem_init = 1'b0; req_valid = 1'b0;

    foreach (vt[i]) begin
      model(vt[i].we, vt[i].size, vt[i].sgn, vt[i].addr, vt[i].wdata, m);
      e = m;
      e.fault = vt[i].fault;
      e.rdata = vt[i].rdata;
      e.word  = vt[i].word;
      e.lat   = vt[i].lat;
      e.wes   = (!vt[i].fault && vt[i].we) ? 1 : 0;
      issue(vt[i].we, vt[i].size, vt[i].sgn, vt[i].addr, vt[i].wdata, e);
    end

    // Byte store to word 1 aborted by reset during its write cycle.
    @(posedge clk); #1;
    req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h4; req_wdata = 32'hAB;
    req_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check("abort_mem_we", 32'(mem_we), 32'h0);
    check("abort_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    ref_rdata = 32'h0;
    @(negedge clk);
    check("post_rst_done", 32'(done), 32'h0);
    check("post_rst_fault", 32'(fault), 32'h0);
    check("post_rst_stall", 32'(stall), 32'h0);
    check("post_rst_mem_we", 32'(mem_we), 32'h0);
    check("post_rst_rdata", rdata, 32'h0);
    check("post_rst_mem_addr", mem_addr, 32'h0);
    check("post_rst_mem_wd", mem_wd, 32'h0);
    check("abort_mem1", mem[1], ref_mem[1]);
    @(posedge clk); #1;
    model(1'b1, 2'b00, 1'b0, 32'h4, 32'hAB, e);
    issue(1'b1, 2'b00, 1'b0, 32'h4, 32'hAB, e);

    // Random back-to-back stream against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic        we, sgn;
      logic [1:0]  size;
      logic [31:0] wd;
      a    = (32'($urandom_range(0, 103)) << 2) | 32'($urandom_range(0, 3));
      we   = 1'($urandom_range(0, 1));
      sgn  = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      wd   = $urandom;
      model(we, size, sgn, a, wd, e);
      issue(we, size, sgn, a, wd, e);
    end

    repeat (3) @(posedge clk);
    check("queue_empty", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
